// File: rtl/fxp_sqrt_pkg.sv
// Shared types and default widths for the fixed-point square-root arbiter.
package fxp_sqrt_pkg;

  localparam int DEF_INTEGER_WIDTH  = 16;
  localparam int DEF_FRACTION_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } fsm_state_e;

endpackage

// File: rtl/fxp_rr_picker.sv
// Round-robin picker: finds the first valid requester after last_grant_i,
// wrapping around, and reports it as one-hot, as an index and as any_valid.
module fxp_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o,
  output logic               any_valid_o
);

  logic [IDW-1:0] idx;
  logic           found;

  // The requester just served is visited last, so it has the lowest priority.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/fxp_sqrt_arbiter.sv
// Shares one fixed-point sqrt engine among NUM_REQ requesters, one request in flight.
// Optional engine watchdog enabled by defining FXP_SQRT_TIMEOUT_EN.
module fxp_sqrt_arbiter
  import fxp_sqrt_pkg::*;
#(
  parameter int INTEGER_WIDTH  = DEF_INTEGER_WIDTH,
  parameter int FRACTION_WIDTH = DEF_FRACTION_WIDTH,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [NUM_REQ-1:0]                                 req_valid,
  input  logic [NUM_REQ*(INTEGER_WIDTH+FRACTION_WIDTH)-1:0]  req_num,
  output logic [NUM_REQ-1:0]                                 req_ready,
  output logic                                               eng_start,
  output logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0]            eng_num,
  input  logic                                               eng_done,
  input  logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0]            eng_root,
  output logic                                               rsp_valid,
  input  logic                                               rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                         rsp_id,
  output logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0]            rsp_root,
  output logic                                               rsp_err
);

  localparam int W   = INTEGER_WIDTH + FRACTION_WIDTH;
  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fxp_sqrt_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  fsm_state_e state_q, state_d;

  logic [IDW-1:0]     lastGrant_q;
  logic [IDW-1:0]     rspId_q;
  logic [W-1:0]       opNum_q;
  logic [W-1:0]       rspRoot_q;
  logic [W-1:0]       reqOperand [NUM_REQ];
  logic [NUM_REQ-1:0] pickGrant;
  logic [IDW-1:0]     pickIdx;
  logic               anyValid;
  logic               accept;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqOperand[i] = req_num[i*W +: W];
    end
  end

  fxp_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .valid_i      (req_valid),
    .last_grant_i (lastGrant_q),
    .grant_o      (pickGrant),
    .grant_idx_o  (pickIdx),
    .any_valid_o  (anyValid)
  );

  assign accept = (state_q == ST_IDLE) && anyValid;

`ifdef FXP_SQRT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timeoutCnt_q;
  logic          rspErr_q;
  logic          timeoutHit;

  assign timeoutHit = (timeoutCnt_q == TMO_LAST);

  // Counter restarts from zero each time WAIT is entered; rsp_root stays at the
  // zero written on acceptance when the watchdog fires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeoutCnt_q <= '0;
      rspErr_q     <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) begin
        timeoutCnt_q <= '0;
      end else if (state_q == ST_WAIT && !eng_done && !timeoutHit) begin
        timeoutCnt_q <= timeoutCnt_q + 1'b1;
      end
      if (accept) begin
        rspErr_q <= 1'b0;
      end else if (state_q == ST_WAIT && !eng_done && timeoutHit) begin
        rspErr_q <= 1'b1;
      end
    end
  end

  assign rsp_err = rspErr_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (anyValid) begin
          state_d = (reqOperand[pickIdx] == '0) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          state_d = ST_RESP;
`ifdef FXP_SQRT_TIMEOUT_EN
        end else if (timeoutHit) begin
          state_d = ST_RESP;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // req_ready is also masked by rst_n so nothing looks granted while reset is held.
  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    eng_num   = '0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready = rst_n ? pickGrant : '0;
      ST_ISSUE: begin
        eng_start = 1'b1;
        eng_num   = opNum_q;
      end
      ST_WAIT:  eng_num = opNum_q;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastGrant_q <= IDW'(NUM_REQ - 1);
      rspId_q     <= '0;
      opNum_q     <= '0;
      rspRoot_q   <= '0;
    end else begin
      if (accept) begin
        opNum_q     <= reqOperand[pickIdx];
        rspId_q     <= pickIdx;
        lastGrant_q <= pickIdx;
        rspRoot_q   <= '0;
      end else if (state_q == ST_WAIT && eng_done) begin
        rspRoot_q <= eng_root;
      end
    end
  end

  assign rsp_id   = rspId_q;
  assign rsp_root = rspRoot_q;

endmodule

// File: tb/tb_fxp_sqrt_arbiter.sv
// Directed self-checking bench for fxp_sqrt_arbiter (Q16.16, 4 requesters) with a
// behavioural sqrt engine that answers 5 cycles after eng_start.
module tb_fxp_sqrt_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_num;
  logic [3:0]   req_ready;
  logic         eng_start;
  logic [31:0]  eng_num;
  logic         eng_done;
  logic [31:0]  eng_root;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_root;
  logic         rsp_err;

  int numChecks = 0;
  int numErrors = 0;

  fxp_sqrt_arbiter #(
    .INTEGER_WIDTH  (16),
    .FRACTION_WIDTH (16),
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_ready (req_ready),
    .eng_start (eng_start),
    .eng_num   (eng_num),
    .eng_done  (eng_done),
    .eng_root  (eng_root),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_root  (rsp_root),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural engine: integer sqrt of (operand << 16) keeps the Q16.16 format.
  logic        autoDone = 1'b0;
  logic        manualDone = 1'b0;
  logic [31:0] autoRoot = '0;
  logic [31:0] manualRoot = '0;
  logic [31:0] engOperand = '0;
  int          engCnt = 0;
  int          engStartCount = 0;
  bit          engAuto = 1'b1;

  assign eng_done = autoDone | manualDone;
  assign eng_root = manualDone ? manualRoot : autoRoot;

  function automatic logic [31:0] isqrtQ(input logic [31:0] n);
    logic [63:0] x;
    logic [63:0] r;
    logic [63:0] t;
    x = {16'd0, n, 16'd0};
    r = '0;
    for (int b = 23; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[31:0];
  endfunction

  always @(negedge clk) begin
    autoDone = 1'b0;
    if (engCnt > 0) begin
      engCnt--;
      if (engCnt == 0 && engAuto) begin
        autoDone = 1'b1;
        autoRoot = isqrtQ(engOperand);
      end
    end
    if (eng_start === 1'b1) begin
      engCnt = 5;
      engOperand = eng_num;
      engStartCount++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setNum(input int i, input logic [31:0] v);
    req_num[i*32 +: 32] = v;
  endtask

  task automatic waitRsp(input int limit, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < limit) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic ackRsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Reset values while rst_n is held, even with every requester asking.
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    setNum(0, 32'h0001_0000);
    setNum(1, 32'h0004_0000);
    setNum(2, 32'h0009_0000);
    setNum(3, 32'h0019_0000);
    tick();
    tick();
    numChecks++; if (req_ready !== 4'b0000) begin numErrors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    numChecks++; if (eng_start !== 1'b0 || eng_num !== 32'h0) begin numErrors++; $display("[TB] FAIL reset_engine: got start=%b num=%h expected 0/0", eng_start, eng_num); end
    numChecks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_root !== 32'h0 || rsp_err !== 1'b0) begin numErrors++; $display("[TB] FAIL reset_rsp: got v=%b id=%0d root=%h err=%b expected all 0", rsp_valid, rsp_id, rsp_root, rsp_err); end
    req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  // Single engine request from requester 2, plus an eng_done during ISSUE to be ignored.
  task automatic test_basic();
    int cyc;
    bit ok;
    setNum(2, 32'h0004_0000);
    req_valid = 4'b0100;
    #1;
    numChecks++; if (req_ready !== 4'b0100) begin numErrors++; $display("[TB] FAIL basic_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    numChecks++; if (eng_start !== 1'b1 || eng_num !== 32'h0004_0000) begin numErrors++; $display("[TB] FAIL basic_issue: got start=%b num=%h expected 1/00040000", eng_start, eng_num); end
    numChecks++; if (req_ready !== 4'b0000) begin numErrors++; $display("[TB] FAIL basic_busy_ready: got %b expected 0000", req_ready); end
    manualRoot = 32'hDEAD_BEEF;
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    numChecks++; if (eng_start !== 1'b0 || eng_num !== 32'h0004_0000 || rsp_valid !== 1'b0) begin numErrors++; $display("[TB] FAIL basic_wait: got start=%b num=%h rsp_valid=%b expected 0/00040000/0", eng_start, eng_num, rsp_valid); end
    waitRsp(20, cyc, ok);
    numChecks++; if (!ok || cyc != 5) begin numErrors++; $display("[TB] FAIL basic_latency: got ok=%b cycles=%0d expected 1/5", ok, cyc); end
    numChecks++; if (rsp_id !== 2'd2 || rsp_root !== 32'h0002_0000 || rsp_err !== 1'b0) begin numErrors++; $display("[TB] FAIL basic_rsp: got id=%0d root=%h err=%b expected 2/00020000/0", rsp_id, rsp_root, rsp_err); end
    ackRsp();
    numChecks++; if (rsp_valid !== 1'b0) begin numErrors++; $display("[TB] FAIL basic_release: got rsp_valid=%b expected 0", rsp_valid); end
  endtask

  // All four requesters continuously valid after reset.
  task automatic test_round_robin();
    int          cyc;
    bit          ok;
    logic [3:0]  expGrant [5];
    logic [1:0]  expId [5];
    logic [31:0] expRoot [5];
    expGrant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    expId    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    expRoot  = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0005_0000, 32'h0001_0000};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    setNum(0, 32'h0001_0000);
    setNum(1, 32'h0004_0000);
    setNum(2, 32'h0009_0000);
    setNum(3, 32'h0019_0000);
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      numChecks++; if (req_ready !== expGrant[n]) begin numErrors++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", n, req_ready, expGrant[n]); end
      tick();
      if (n == 4) req_valid = 4'b0000;
      waitRsp(20, cyc, ok);
      numChecks++; if (!ok || rsp_id !== expId[n] || rsp_root !== expRoot[n]) begin numErrors++; $display("[TB] FAIL rr_rsp_%0d: got ok=%b id=%0d root=%h expected 1/%0d/%h", n, ok, rsp_id, rsp_root, expId[n], expRoot[n]); end
      ackRsp();
    end
  endtask

  // Zero operand answers directly without touching the engine.
  task automatic test_zero_bypass();
    int startsBefore;
    startsBefore = engStartCount;
    setNum(1, 32'h0);
    req_valid = 4'b0010;
    #1;
    numChecks++; if (req_ready !== 4'b0010) begin numErrors++; $display("[TB] FAIL zero_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    numChecks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_root !== 32'h0 || rsp_err !== 1'b0 || eng_start !== 1'b0) begin numErrors++; $display("[TB] FAIL zero_rsp: got v=%b id=%0d root=%h err=%b start=%b expected 1/1/0/0/0", rsp_valid, rsp_id, rsp_root, rsp_err, eng_start); end
    ackRsp();
    tick();
    numChecks++; if (engStartCount != startsBefore) begin numErrors++; $display("[TB] FAIL zero_no_start: got %0d starts expected %0d", engStartCount, startsBefore); end
  endtask

  // Response held for 10 cycles, waiting requester accepted right after release.
  task automatic test_backpressure();
    int cyc;
    bit ok;
    setNum(3, 32'h0009_0000);
    setNum(0, 32'h0001_0000);
    req_valid = 4'b1000;
    #1;
    numChecks++; if (req_ready !== 4'b1000) begin numErrors++; $display("[TB] FAIL bp_grant: got %b expected 1000", req_ready); end
    tick();
    req_valid = 4'b0001;
    waitRsp(20, cyc, ok);
    numChecks++; if (!ok) begin numErrors++; $display("[TB] FAIL bp_rsp_timeout: got no rsp_valid after %0d cycles expected response", cyc); end
    for (int c = 0; c < 10; c++) begin
      numChecks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_root !== 32'h0003_0000 || req_ready !== 4'b0000) begin numErrors++; $display("[TB] FAIL bp_hold_%0d: got v=%b id=%0d root=%h ready=%b expected 1/3/00030000/0000", c, rsp_valid, rsp_id, rsp_root, req_ready); end
      tick();
    end
    ackRsp();
    numChecks++; if (req_ready !== 4'b0001) begin numErrors++; $display("[TB] FAIL bp_next_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    numChecks++; if (eng_start !== 1'b1 || eng_num !== 32'h0001_0000) begin numErrors++; $display("[TB] FAIL bp_next_issue: got start=%b num=%h expected 1/00010000", eng_start, eng_num); end
    waitRsp(20, cyc, ok);
    numChecks++; if (!ok || rsp_id !== 2'd0 || rsp_root !== 32'h0001_0000) begin numErrors++; $display("[TB] FAIL bp_next_rsp: got ok=%b id=%0d root=%h expected 1/0/00010000", ok, rsp_id, rsp_root); end
    ackRsp();
  endtask

  // Requester 1 withdraws while busy; requester 2 must be served instead.
  task automatic test_skip();
    int cyc;
    bit ok;
    setNum(0, 32'h0001_0000);
    setNum(1, 32'h0009_0000);
    setNum(2, 32'h0004_0000);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0110;
    waitRsp(20, cyc, ok);
    req_valid = 4'b0100;
    tick();
    numChecks++; if (!ok || req_ready !== 4'b0000) begin numErrors++; $display("[TB] FAIL skip_busy: got ok=%b ready=%b expected 1/0000", ok, req_ready); end
    ackRsp();
    numChecks++; if (req_ready !== 4'b0100) begin numErrors++; $display("[TB] FAIL skip_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    waitRsp(20, cyc, ok);
    numChecks++; if (!ok || rsp_id !== 2'd2 || rsp_root !== 32'h0002_0000) begin numErrors++; $display("[TB] FAIL skip_rsp: got ok=%b id=%0d root=%h expected 1/2/00020000", ok, rsp_id, rsp_root); end
    ackRsp();
  endtask

`ifdef FXP_SQRT_TIMEOUT_EN
  // Silent engine: watchdog fires after 8 WAIT cycles, late eng_done has no effect.
  task automatic test_timeout();
    int cyc;
    bit ok;
    engAuto = 1'b0;
    setNum(0, 32'h0004_0000);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    waitRsp(20, cyc, ok);
    numChecks++; if (!ok || cyc != 8) begin numErrors++; $display("[TB] FAIL tmo_latency: got ok=%b cycles=%0d expected 1/8", ok, cyc); end
    numChecks++; if (rsp_err !== 1'b1 || rsp_root !== 32'h0 || rsp_id !== 2'd0) begin numErrors++; $display("[TB] FAIL tmo_rsp: got err=%b root=%h id=%0d expected 1/0/0", rsp_err, rsp_root, rsp_id); end
    manualRoot = 32'h0000_ABCD;
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    numChecks++; if (rsp_valid !== 1'b1 || rsp_root !== 32'h0 || rsp_err !== 1'b1) begin numErrors++; $display("[TB] FAIL tmo_late_done: got v=%b root=%h err=%b expected 1/0/1", rsp_valid, rsp_root, rsp_err); end
    ackRsp();
    engAuto = 1'b1;
  endtask
`endif

  // Reset during WAIT drops the request; the engine's late answer is ignored.
  task automatic test_reset_wait();
    int cyc;
    bit ok;
    bit sawRsp;
    setNum(3, 32'h0019_0000);
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    tick();
    numChecks++; if (eng_num !== 32'h0019_0000 || rsp_id !== 2'd3) begin numErrors++; $display("[TB] FAIL rstw_in_wait: got num=%h id=%0d expected 00190000/3", eng_num, rsp_id); end
    rst_n = 1'b0;
    tick();
    numChecks++; if (eng_num !== 32'h0 || eng_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_id !== 2'd0 || rsp_root !== 32'h0 || rsp_err !== 1'b0) begin numErrors++; $display("[TB] FAIL rstw_outputs: got num=%h start=%b v=%b ready=%b id=%0d root=%h err=%b expected all 0", eng_num, eng_start, rsp_valid, req_ready, rsp_id, rsp_root, rsp_err); end
    rst_n = 1'b1;
    sawRsp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid !== 1'b0 || eng_start !== 1'b0) sawRsp = 1'b1;
    end
    numChecks++; if (sawRsp) begin numErrors++; $display("[TB] FAIL rstw_no_rsp: got activity after abort expected none"); end
    setNum(0, 32'h0001_0000);
    setNum(1, 32'h0004_0000);
    req_valid = 4'b0011;
    #1;
    numChecks++; if (req_ready !== 4'b0001) begin numErrors++; $display("[TB] FAIL rstw_priority: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    waitRsp(20, cyc, ok);
    numChecks++; if (!ok || rsp_id !== 2'd0 || rsp_root !== 32'h0001_0000) begin numErrors++; $display("[TB] FAIL rstw_after: got ok=%b id=%0d root=%h expected 1/0/00010000", ok, rsp_id, rsp_root); end
    ackRsp();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b0000;
    req_num = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_bypass();
    test_backpressure();
    test_skip();
`ifdef FXP_SQRT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
